// File: rtl/prog_loader.sv
// Byte-stream program loader: deframes HEADER / N / N*3 payload bytes / CSUM,
// assembles 24-bit instruction words and writes them to program RAM from
// LOAD_BASE upward. Holds the CPU off (busy) while a frame is in flight.
module prog_loader #(
    parameter int unsigned RAM_WORD_WIDTH = 24,
    parameter int unsigned RAM_ADDR_BITS  = 8,
    parameter int unsigned LOAD_BASE      = 1,
    parameter logic [7:0]  HEADER         = 8'hA5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [7:0]                rx_data,
    input  logic                      rx_valid,
    output logic                      rx_ready,
    output logic                      wr_en,
    output logic [RAM_ADDR_BITS-1:0]  wr_addr,
    output logic [RAM_WORD_WIDTH-1:0] wr_data,
    output logic                      busy,
    output logic                      done,
    output logic                      err
);

    typedef enum logic [2:0] {
        StIdle,
        StCount,
        StB0,
        StB1,
        StB2,
        StWrite,
        StCsum
    } state_e;

    state_e                    state_q, state_d;
    logic [7:0]                cnt_q, cnt_d;
    logic [RAM_ADDR_BITS-1:0]  addr_q, addr_d;
    logic [RAM_WORD_WIDTH-1:0] word_q, word_d;
    logic [7:0]                csum_q, csum_d;
    // full: address already past the top of RAM; ovf: a word was actually dropped
    logic                      full_q, full_d;
    logic                      ovf_q, ovf_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic                      err_q, err_d;
    logic                      accept;

    assign rx_ready = (state_q != StWrite);
    assign accept   = rx_valid && rx_ready;
    assign wr_en    = (state_q == StWrite) && !full_q;
    assign wr_addr  = addr_q;
    assign wr_data  = word_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            addr_q  <= '0;
            word_q  <= '0;
            csum_q  <= '0;
            full_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            word_q  <= word_d;
            csum_q  <= csum_d;
            full_q  <= full_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Frame deframing, word assembly and checksum next-state logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        word_d  = word_q;
        csum_d  = csum_q;
        full_d  = full_q;
        ovf_d   = ovf_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = err_q;

        unique case (state_q)
            StIdle: begin
                if (accept && (rx_data == HEADER)) begin
                    state_d = StCount;
                    err_d   = 1'b0;
                    csum_d  = '0;
                    full_d  = 1'b0;
                    ovf_d   = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            StCount: begin
                if (accept) begin
                    cnt_d   = rx_data;
                    csum_d  = csum_q ^ rx_data;
                    addr_d  = RAM_ADDR_BITS'(LOAD_BASE);
                    state_d = (rx_data == 8'd0) ? StCsum : StB0;
                end
            end
            StB0: begin
                if (accept) begin
                    word_d[23:16] = rx_data;
                    csum_d        = csum_q ^ rx_data;
                    state_d       = StB1;
                end
            end
            StB1: begin
                if (accept) begin
                    word_d[15:8] = rx_data;
                    csum_d       = csum_q ^ rx_data;
                    state_d      = StB2;
                end
            end
            StB2: begin
                if (accept) begin
                    word_d[7:0] = rx_data;
                    csum_d      = csum_q ^ rx_data;
                    state_d     = StWrite;
                end
            end
            StWrite: begin
                cnt_d = cnt_q - 8'd1;
                // Past the top of RAM the word is consumed but not written; no wrap.
                if (full_q) begin
                    ovf_d = 1'b1;
                end else if (addr_q == {RAM_ADDR_BITS{1'b1}}) begin
                    full_d = 1'b1;
                end else begin
                    addr_d = addr_q + 1'b1;
                end
                state_d = (cnt_q == 8'd1) ? StCsum : StB0;
            end
            StCsum: begin
                if (accept) begin
                    err_d   = (rx_data != csum_q) | ovf_q;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: scoreboard queues hold expected writes and
// done/err results; monitors pop and compare as the DUTs produce them.
module tb_prog_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        v_lo, v_hi;

    logic        rdy_lo, we_lo, busy_lo, done_lo, err_lo;
    logic [7:0]  wa_lo;
    logic [23:0] wd_lo;
    logic        rdy_hi, we_hi, busy_hi, done_hi, err_hi;
    logic [7:0]  wa_hi;
    logic [23:0] wd_hi;

    int compared   = 0;
    int mismatched = 0;

    logic [31:0] exp_wr_lo[$];
    logic [31:0] exp_wr_hi[$];
    logic        exp_done_lo[$];
    logic        exp_done_hi[$];

    logic [23:0] words[0:3];
    logic        sel_hi   = 1'b0;
    logic        busy_exp = 1'b0;
    logic [31:0] e_lo, e_hi;
    logic        d_lo, d_hi;

    always #5 clk = ~clk;

    prog_loader u_lo (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx_data  (rx_data),
        .rx_valid (v_lo),
        .rx_ready (rdy_lo),
        .wr_en    (we_lo),
        .wr_addr  (wa_lo),
        .wr_data  (wd_lo),
        .busy     (busy_lo),
        .done     (done_lo),
        .err      (err_lo)
    );

    prog_loader #(.LOAD_BASE(254)) u_hi (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx_data  (rx_data),
        .rx_valid (v_hi),
        .rx_ready (rdy_hi),
        .wr_en    (we_hi),
        .wr_addr  (wa_hi),
        .wr_data  (wd_hi),
        .busy     (busy_hi),
        .done     (done_hi),
        .err      (err_hi)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_lo();
        chk("rst_rx_ready", 32'(rdy_lo), 32'd1);
        chk("rst_wr_en", 32'(we_lo), 32'd0);
        chk("rst_wr_addr", 32'(wa_lo), 32'd0);
        chk("rst_wr_data", 32'(wd_lo), 32'd0);
        chk("rst_busy", 32'(busy_lo), 32'd0);
        chk("rst_done", 32'(done_lo), 32'd0);
        chk("rst_err", 32'(err_lo), 32'd0);
    endtask

    // Offer one byte, wait (bounded) for ready, transfer it, then idle 'gap' cycles.
    task automatic send(input logic [7:0] b, input int gap);
        int n;
        n = 0;
        @(negedge clk);
        rx_data = b;
        if (sel_hi) v_hi = 1'b1;
        else        v_lo = 1'b1;
        while (((sel_hi ? rdy_hi : rdy_lo) == 1'b0) && (n < 8)) begin
            @(negedge clk);
            n++;
        end
        if (n >= 8) chk("ready_timeout", 32'(sel_hi ? rdy_hi : rdy_lo), 32'd1);
        @(posedge clk);
        #1;
        v_lo = 1'b0;
        v_hi = 1'b0;
        chk("busy", 32'(sel_hi ? busy_hi : busy_lo), 32'(busy_exp));
        repeat (gap) @(negedge clk);
    endtask

    // Send a complete frame of n words from words[], pushing the expected results.
    task automatic send_frame(input int n, input int gap, input logic bad);
        logic [7:0] cs;
        int         base;
        int         a;
        logic       ovf;
        base = sel_hi ? 254 : 1;
        cs   = n[7:0];
        ovf  = 1'b0;
        for (int i = 0; i < n; i++) begin
            a = base + i;
            if (a <= 255) begin
                if (sel_hi) exp_wr_hi.push_back({a[7:0], words[i]});
                else        exp_wr_lo.push_back({a[7:0], words[i]});
            end else begin
                ovf = 1'b1;
            end
            cs = cs ^ words[i][23:16] ^ words[i][15:8] ^ words[i][7:0];
        end
        if (bad) cs = cs ^ 8'h01;
        if (sel_hi) exp_done_hi.push_back(bad | ovf);
        else        exp_done_lo.push_back(bad | ovf);

        busy_exp = 1'b1;
        send(8'hA5, gap);
        chk("err_clear_on_header", 32'(sel_hi ? err_hi : err_lo), 32'd0);
        send(n[7:0], gap);
        for (int i = 0; i < n; i++) begin
            send(words[i][23:16], gap);
            send(words[i][15:8], gap);
            send(words[i][7:0], gap);
        end
        busy_exp = 1'b0;
        send(cs, gap);
    endtask

    // Write/done scoreboard and ready-vs-write check for the base-1 instance.
    always @(negedge clk) begin
        if (we_lo) begin
            if (exp_wr_lo.size() == 0) begin
                chk("unexpected_wr_lo", 32'(we_lo), 32'd0);
            end else begin
                e_lo = exp_wr_lo.pop_front();
                chk("wr_lo", {wa_lo, wd_lo}, e_lo);
            end
        end
        if (done_lo) begin
            if (exp_done_lo.size() == 0) begin
                chk("unexpected_done_lo", 32'(done_lo), 32'd0);
            end else begin
                d_lo = exp_done_lo.pop_front();
                chk("err_at_done_lo", 32'(err_lo), 32'(d_lo));
                chk("busy_at_done_lo", 32'(busy_lo), 32'd0);
            end
        end
        if (rst_n) chk("ready_vs_write_lo", 32'(rdy_lo), 32'(!we_lo));
    end

    // Write/done scoreboard for the LOAD_BASE=254 instance.
    always @(negedge clk) begin
        if (we_hi) begin
            if (exp_wr_hi.size() == 0) begin
                chk("unexpected_wr_hi", 32'(we_hi), 32'd0);
            end else begin
                e_hi = exp_wr_hi.pop_front();
                chk("wr_hi", {wa_hi, wd_hi}, e_hi);
            end
        end
        if (done_hi) begin
            if (exp_done_hi.size() == 0) begin
                chk("unexpected_done_hi", 32'(done_hi), 32'd0);
            end else begin
                d_hi = exp_done_hi.pop_front();
                chk("err_at_done_hi", 32'(err_hi), 32'(d_hi));
                chk("busy_at_done_hi", 32'(busy_hi), 32'd0);
            end
        end
    end

    initial begin
        rst_n   = 1'b0;
        rx_data = 8'h00;
        v_lo    = 1'b0;
        v_hi    = 1'b0;
        #1;
        check_reset_lo();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // 1: basic two-word frame
        words[0] = 24'h010005;
        words[1] = 24'h030001;
        send_frame(2, 0, 1'b0);
        repeat (3) @(negedge clk);
        chk("t1_err", 32'(err_lo), 32'd0);
        chk("t1_wr_pending", 32'(exp_wr_lo.size()), 32'd0);

        // 2: bad checksum, err sticky until next header
        send_frame(2, 0, 1'b1);
        repeat (4) @(negedge clk);
        chk("t2_err_sticky", 32'(err_lo), 32'd1);
        send_frame(2, 0, 1'b0);
        repeat (3) @(negedge clk);

        // 3: junk before header, zero-length frame
        busy_exp = 1'b0;
        send(8'h00, 0);
        send(8'h7F, 0);
        send_frame(0, 0, 1'b0);
        repeat (3) @(negedge clk);
        chk("t3_err", 32'(err_lo), 32'd0);

        // 4: stalled stream
        send_frame(2, 5, 1'b0);
        repeat (3) @(negedge clk);

        // 5: address overflow at top of RAM; HEADER values inside payload
        sel_hi   = 1'b1;
        words[0] = 24'hA50001;
        words[1] = 24'h0200A5;
        words[2] = 24'h333333;
        send_frame(3, 0, 1'b0);
        repeat (3) @(negedge clk);
        chk("t5_err", 32'(err_hi), 32'd1);
        sel_hi = 1'b0;

        // 6: reset mid-frame, then a normal frame from LOAD_BASE
        busy_exp = 1'b1;
        send(8'hA5, 0);
        send(8'h02, 0);
        send(8'h01, 0);
        send(8'h00, 0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_lo();
        @(negedge clk);
        rst_n    = 1'b1;
        busy_exp = 1'b0;
        words[0] = 24'h010005;
        words[1] = 24'h030001;
        send_frame(2, 0, 1'b0);
        repeat (5) @(negedge clk);

        chk("end_wr_lo_empty", 32'(exp_wr_lo.size()), 32'd0);
        chk("end_wr_hi_empty", 32'(exp_wr_hi.size()), 32'd0);
        chk("end_done_lo_empty", 32'(exp_done_lo.size()), 32'd0);
        chk("end_done_hi_empty", 32'(exp_done_hi.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Byte-stream program loader: the write side of the 24-bit instruction memory that the fetch path reads.
- Receives a framed byte stream over a valid/ready handshake, e.g. from a UART receiver or test host.
- Assembles each group of 3 bytes into one instruction word and writes it to program RAM starting at LOAD_BASE.
- Verifies an XOR checksum and holds the CPU off while a load is in progress.

Parameters:
- RAM_WORD_WIDTH, 24, instruction word width; fixed at 3 bytes (opcode byte + 16-bit operand).
- RAM_ADDR_BITS, 8, program memory address width.
- LOAD_BASE, 1, first word address written; word 0 stays the reset NOP.
- HEADER, 8'hA5, frame start byte.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- rx_data  in  8  incoming byte.
- rx_valid  in  1  rx_data valid.
- rx_ready  out  1  loader can accept a byte; a byte transfers when rx_valid && rx_ready at posedge.
- wr_en  out  1  program RAM write strobe, one cycle per word.
- wr_addr  out  RAM_ADDR_BITS  write address.
- wr_data  out  RAM_WORD_WIDTH  write word, {opcode, operand[15:8], operand[7:0]}.
- busy  out  1  high from header accept until frame end; drives CPU hold.
- done  out  1  one-cycle pulse at frame end.
- err  out  1  sticky error flag; cleared when the next header is accepted.

Behaviour:
Reset:
- rst_n low asynchronously forces state IDLE.
- Outputs during reset: rx_ready=1, wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0, err=0.
- Internal count, byte index and checksum are cleared.
- Reset mid-frame abandons the frame; words already written stay in RAM; no done pulse is produced.

Frame format, in order:
- HEADER.
- N, the word count (0..255).
- N×3 payload bytes, MSB first per word.
- CSUM = XOR of N and all payload bytes.

States:
- IDLE: accepted bytes other than HEADER are discarded. HEADER → COUNT; clear err and checksum; set busy.
- COUNT: accept N; checksum ^= N; word address := LOAD_BASE. N==0 → CSUM, else → B0.
- B0, B1, B2: accept one byte each into word[23:16], word[15:8], word[7:0]; checksum ^= byte.
  - On the B2 accept: → WRITE.
- WRITE: one cycle with rx_ready=0.
  - wr_en=1 with wr_addr = current address and wr_data = the assembled word.
  - Address increments; remaining count decrements.
  - Remaining 0 → CSUM, else → B0.
- CSUM: accept one byte; err := (byte != checksum) | overflow.
  - busy drops and done pulses on the cycle after the accept; → IDLE.

Handshake and timing:
- rx_ready=1 in every state except WRITE.
- Latency: wr_en is asserted in the cycle immediately after the third byte of a word is accepted.
- rx_valid may stall arbitrarily between bytes; state is held, and nothing is accepted without rx_valid.

Address overflow:
- When the address would exceed 2^RAM_ADDR_BITS−1, further words are still consumed and checksummed, but wr_en is suppressed. The overflow flag is set and reported through err at the CSUM step.
- The address does not wrap.

Other rules:
- err asserts together with done; no writes are rolled back.
- HEADER bytes inside the payload are treated as data (no resync).

Test Plan:
1. A5, 02, 01 00 05, 03 00 01, CSUM=02^01^05^03^01=04 → wr_en twice: addr 1 data 0x010005, then addr 2 data 0x030001. done pulses, err=0, busy high for the whole frame.
2. Same frame with CSUM=0x05 → both writes occur; done and err=1. A following good frame's header clears err.
3. Bytes 00, 7F, then A5, 00, 00 → leading bytes ignored, zero writes, done pulses, err=0.
4. Frame 1 with rx_valid deasserted for 5 cycles between every byte → identical writes and data; rx_ready low only in the WRITE cycles.
5. LOAD_BASE=254, N=3 → writes to addr 254 and 255 only; third word suppressed; err=1 at done.
6. rst_n pulsed low after the second payload byte of word 1 → outputs return to reset values immediately. No write, no done; a subsequent full frame loads normally from LOAD_BASE.
